axi_write_ctrl: RTL and testbench
=================================

# axi_write_ctrl

AXI4-Lite write-channel controller for the AXI register block. It independently captures write address (AW) and write data (W) beats and issues exactly one single-cycle register write request per transaction to the lane-enable/register datapath, supplying byte offset, register index, data, strobes and the error flag. It then returns the B response. It is the only source of `w_req_in`, `w_error`, `byte_offset` and `w_strb` for the lane-enable logic.

## Interface
Parameters:
- ADDR_WIDTH, 8: AXI byte-address width, minimum 3.
- NUM_REGS, 16: number of implemented 32-bit registers. Legal range 1..2^(ADDR_WIDTH-2).

Ports:
- clk  input  1  single clock, all logic rising-edge.
- rst  input  1  asynchronous, active-high reset.
- awvalid  input  1  AW valid.
- awready  output  1  AW ready.
- awaddr  input  ADDR_WIDTH  AW byte address.
- wvalid  input  1  W valid.
- wready  output  1  W ready.
- wdata  input  32  W data.
- wstrb  input  4  W byte strobes.
- bvalid  output  1  B valid.
- bready  input  1  B ready.
- bresp  output  2  B response: 2'b00 OKAY, 2'b10 SLVERR.
- w_req  output  1  one-cycle register write request to the datapath.
- w_error  output  1  current request targets a non-existent register. Valid when w_req=1.
- byte_offset  output  2  captured awaddr[1:0].
- reg_idx  output  ADDR_WIDTH-2  captured awaddr[ADDR_WIDTH-1:2].
- w_data  output  32  captured wdata.
- w_strb  output  4  captured wstrb.

## Operation
- Two holding registers:
  - AW slot: addr, aw_full flag.
  - W slot: data, strb, w_full flag.
- awready = ~aw_full and wready = ~w_full. Both are combinational from the flags only, never from valid.
- AW handshake (awvalid & awready) loads the AW slot and sets aw_full.
- W handshake (wvalid & wready) loads the W slot and sets w_full.
- AW and W may arrive in either order or in the same cycle. A W beat with no AW yet is held, not dropped.
- FSM states: IDLE, WRITE, RESP.
  - IDLE -> WRITE on the clock edge where aw_full & w_full holds. The flags may have become full in that same edge's handshake.
  - WRITE lasts exactly one cycle. w_req = 1 only in WRITE. Always transitions to RESP.
  - RESP: bvalid = 1. bresp = 2'b10 if the captured error is set, else 2'b00. bresp is stable while bvalid is high.
  - RESP -> IDLE on bvalid & bready. The same edge clears aw_full and w_full.
- Error rule: w_error = (reg_idx >= NUM_REGS), registered at WRITE entry. An unaligned byte_offset is not an error; the datapath masks the lanes.
- An erroring write still pulses w_req with w_error = 1. The datapath suppresses all lanes.
- Outputs byte_offset, reg_idx, w_data and w_strb are driven directly from the holding registers. They are stable from WRITE through RESP.
- Only one outstanding transaction at a time. No new AW or W is accepted until the B handshake clears both slots.

## Timing
- Reset values:
  - awready = 1, wready = 1, bvalid = 0, bresp = 2'b00, w_req = 0, w_error = 0.
  - byte_offset, reg_idx, w_data, w_strb = 0.
  - FSM = IDLE, both slots empty.
- Latency with AW and W handshaked in cycle N:
  - w_req is high in cycle N+1.
  - bvalid rises in cycle N+2.
- If the later of AW and W is handshaked in cycle N, the same latency applies from N.
- With bready held high, the B handshake completes in N+2. awready and wready return high in N+3. Peak throughput is one write per 3 cycles.
- bvalid is held until bready. Arbitrary bready stalls produce no extra w_req.
- Simultaneous events:
  - A handshake and a flag clear cannot coincide, because ready is low while full.
  - awvalid and wvalid high in the same cycle as the B handshake are not accepted. Ready is low in that cycle.
- Reset asserted mid-transaction (any state): immediately returns to reset values. A pending w_req or bvalid is abandoned, with no spurious pulse after reset release.

## Test plan
- Reset: assert rst for 3 cycles during RESP -> bvalid = 0, awready = 1, wready = 1 asynchronously. No w_req after release.
- Aligned write: AW addr 0x08 and W data 0xDEADBEEF, strb 4'hF, in the same cycle N -> N+1: w_req = 1, reg_idx = 2, byte_offset = 0, w_error = 0. N+2: bvalid = 1, bresp = 2'b00.
- W before AW: W in cycle 5 (strb 4'h3), AW addr 0x0D in cycle 9 -> wready low in cycles 6..9. w_req in cycle 10 with byte_offset = 1, reg_idx = 3, w_strb = 4'h3.
- Out-of-range write (NUM_REGS = 16): AW addr 0x40 -> w_req with w_error = 1, bresp = 2'b10.
- B backpressure: bready low for 10 cycles -> bvalid and bresp stable. Exactly one w_req. awready = wready = 0 until the cycle after bready rises.
- Back-to-back: 8 writes with valids and bready always high -> one w_req per 3 cycles. Data and strobes match each issued beat in order.

Source files
------------

// File: rtl/axi_write_ctrl_if.sv
// AXI4-Lite write channels (AW, W, B) plus the single-cycle register write
// request toward the lane-enable datapath and a debug view of the FSM state.
interface axi_write_ctrl_if #(
    parameter int ADDR_WIDTH = 8
);
    // Every channel handshake completes on a rising edge where valid and ready
    // are both high; valid never waits on ready, and ready here depends only
    // on the slot flags, never on valid.
    logic                  awvalid;
    logic                  awready;
    logic [ADDR_WIDTH-1:0] awaddr;
    logic                  wvalid;
    logic                  wready;
    logic [31:0]           wdata;
    logic [3:0]            wstrb;
    logic                  bvalid;
    logic                  bready;
    logic [1:0]            bresp;
    logic                  w_req;
    logic                  w_error;
    logic [1:0]            byte_offset;
    logic [ADDR_WIDTH-3:0] reg_idx;
    logic [31:0]           w_data;
    logic [3:0]            w_strb;
    logic [1:0]            dbg_state;

    modport master (
        output awvalid, awaddr, wvalid, wdata, wstrb, bready,
        input  awready, wready, bvalid, bresp,
        input  w_req, w_error, byte_offset, reg_idx, w_data, w_strb, dbg_state
    );

    modport slave (
        input  awvalid, awaddr, wvalid, wdata, wstrb, bready,
        output awready, wready, bvalid, bresp,
        output w_req, w_error, byte_offset, reg_idx, w_data, w_strb, dbg_state
    );
endinterface

// File: rtl/axi_write_ctrl.sv
// AXI4-Lite write-channel controller: holds AW and W beats independently, then
// issues one single-cycle register write request and returns the B response.
module axi_write_ctrl #(
    parameter int ADDR_WIDTH = 8,
    parameter int NUM_REGS   = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    axi_write_ctrl_if.slave        bus
);
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        RESP  = 2'd2
    } state_t;

    // One bit wider than reg_idx so NUM_REGS == 2^(ADDR_WIDTH-2) still fits.
    localparam logic [ADDR_WIDTH-2:0] NUM_REGS_W = (ADDR_WIDTH-1)'(NUM_REGS);

    state_t                state_q;
    logic [ADDR_WIDTH-1:0] aw_addr_q;
    logic                  aw_full_q;
    logic [31:0]           w_data_q;
    logic [3:0]            w_strb_q;
    logic                  w_full_q;
    logic                  w_req_q;
    logic                  w_error_q;
    logic                  bvalid_q;
    logic [1:0]            bresp_q;

    logic                  aw_hs;
    logic                  w_hs;
    logic                  aw_full_d;
    logic                  w_full_d;
    logic [ADDR_WIDTH-1:0] aw_addr_d;
    logic                  w_error_d;

    assign aw_hs = bus.awvalid & ~aw_full_q;
    assign w_hs  = bus.wvalid  & ~w_full_q;

    // Slot contents as they will be after this edge's handshakes, so the FSM
    // can start the write on the same edge the second beat lands.
    always_comb begin
        aw_full_d = aw_full_q | aw_hs;
        w_full_d  = w_full_q  | w_hs;
        aw_addr_d = aw_hs ? bus.awaddr : aw_addr_q;
        w_error_d = {1'b0, aw_addr_d[ADDR_WIDTH-1:2]} >= NUM_REGS_W;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            aw_addr_q <= '0;
            aw_full_q <= 1'b0;
            w_data_q  <= '0;
            w_strb_q  <= '0;
            w_full_q  <= 1'b0;
            w_req_q   <= 1'b0;
            w_error_q <= 1'b0;
            bvalid_q  <= 1'b0;
            bresp_q   <= 2'b00;
        end else begin
            if (aw_hs) begin
                aw_addr_q <= bus.awaddr;
                aw_full_q <= 1'b1;
            end
            if (w_hs) begin
                w_data_q <= bus.wdata;
                w_strb_q <= bus.wstrb;
                w_full_q <= 1'b1;
            end

            case (state_q)
                IDLE: begin
                    if (aw_full_d && w_full_d) begin
                        state_q   <= WRITE;
                        w_req_q   <= 1'b1;
                        w_error_q <= w_error_d;
                    end
                end
                WRITE: begin
                    state_q  <= RESP;
                    w_req_q  <= 1'b0;
                    bvalid_q <= 1'b1;
                    bresp_q  <= w_error_q ? 2'b10 : 2'b00;
                end
                RESP: begin
                    // Slots are released only here, so ready stays low until
                    // the cycle after the B handshake.
                    if (bus.bready) begin
                        state_q   <= IDLE;
                        bvalid_q  <= 1'b0;
                        aw_full_q <= 1'b0;
                        w_full_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q  <= IDLE;
                    w_req_q  <= 1'b0;
                    bvalid_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.awready     = ~aw_full_q;
    assign bus.wready      = ~w_full_q;
    assign bus.bvalid      = bvalid_q;
    assign bus.bresp       = bresp_q;
    assign bus.w_req       = w_req_q;
    assign bus.w_error     = w_error_q;
    assign bus.byte_offset = aw_addr_q[1:0];
    assign bus.reg_idx     = aw_addr_q[ADDR_WIDTH-1:2];
    assign bus.w_data      = w_data_q;
    assign bus.w_strb      = w_strb_q;
    assign bus.dbg_state   = state_q;
endmodule

// File: tb/tb_axi_write_ctrl.sv
// Directed bench for axi_write_ctrl: reset, ordering, error, backpressure,
// back-to-back throughput and mid-transaction reset.
module tb_axi_write_ctrl;
    logic clk;
    logic rst;

    int checks   = 0;
    int failures = 0;
    int wreq_cnt = 0;

    logic [41:0] exp_q[$];

    axi_write_ctrl_if #(.ADDR_WIDTH(8)) bus ();

    axi_write_ctrl #(.ADDR_WIDTH(8), .NUM_REGS(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) if (bus.w_req === 1'b1) wreq_cnt++;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        bus.awvalid = 1'b0;
        bus.awaddr  = '0;
        bus.wvalid  = 1'b0;
        bus.wdata   = '0;
        bus.wstrb   = '0;
        bus.bready  = 1'b0;
    endtask

    logic [31:0] data_tbl [8] = '{32'h0000_0001, 32'hA5A5_5A5A, 32'hFFFF_0000, 32'h1234_5678,
                                  32'h8000_0001, 32'h0F0F_F0F0, 32'hCAFE_BABE, 32'h7654_3210};
    logic [3:0]  strb_tbl [8] = '{4'hF, 4'h1, 4'h2, 4'h4, 4'h8, 4'h3, 4'hC, 4'h5};

    initial begin
        int c0;
        int idx;
        int nreq;
        int last_req;
        bit hs_pending;
        logic [41:0] e;

        idle_inputs();
        rst = 1'b1;
        repeat (3) step();
        rst = 1'b0;
        step();

        // Reset values
        check("rst_awready", bus.awready, 1);
        check("rst_wready", bus.wready, 1);
        check("rst_bvalid", bus.bvalid, 0);
        check("rst_bresp", bus.bresp, 0);
        check("rst_w_req", bus.w_req, 0);
        check("rst_w_error", bus.w_error, 0);
        check("rst_byte_offset", bus.byte_offset, 0);
        check("rst_reg_idx", bus.reg_idx, 0);
        check("rst_w_data", bus.w_data, 0);
        check("rst_w_strb", bus.w_strb, 0);

        // Aligned write, AW and W in the same cycle N
        bus.awvalid = 1'b1; bus.awaddr = 8'h08;
        bus.wvalid = 1'b1; bus.wdata = 32'hDEAD_BEEF; bus.wstrb = 4'hF;
        step();
        idle_inputs();
        check("al_w_req", bus.w_req, 1);
        check("al_reg_idx", bus.reg_idx, 2);
        check("al_byte_offset", bus.byte_offset, 0);
        check("al_w_error", bus.w_error, 0);
        check("al_w_data", bus.w_data, 32'hDEAD_BEEF);
        check("al_w_strb", bus.w_strb, 4'hF);
        check("al_awready_busy", bus.awready, 0);
        step();
        check("al_w_req_drop", bus.w_req, 0);
        check("al_bvalid", bus.bvalid, 1);
        check("al_bresp", bus.bresp, 2'b00);
        bus.bready = 1'b1;
        step();
        bus.bready = 1'b0;
        check("al_bvalid_done", bus.bvalid, 0);
        check("al_awready_back", bus.awready, 1);
        check("al_wready_back", bus.wready, 1);

        // W before AW, then B backpressure
        bus.wvalid = 1'b1; bus.wdata = 32'h1122_3344; bus.wstrb = 4'h3;
        step();
        bus.wvalid = 1'b0; bus.wdata = '0; bus.wstrb = '0;
        for (int i = 0; i < 3; i++) begin
            check("wa_wready_low", bus.wready, 0);
            check("wa_awready_high", bus.awready, 1);
            check("wa_no_w_req", bus.w_req, 0);
            step();
        end
        bus.awvalid = 1'b1; bus.awaddr = 8'h0D;
        check("wa_wready_low_aw", bus.wready, 0);
        c0 = wreq_cnt;
        step();
        bus.awvalid = 1'b0; bus.awaddr = '0;
        check("wa_w_req", bus.w_req, 1);
        check("wa_byte_offset", bus.byte_offset, 1);
        check("wa_reg_idx", bus.reg_idx, 3);
        check("wa_w_strb", bus.w_strb, 4'h3);
        check("wa_w_data", bus.w_data, 32'h1122_3344);
        check("wa_w_error", bus.w_error, 0);
        step();
        for (int i = 0; i < 10; i++) begin
            check("bp_bvalid", bus.bvalid, 1);
            check("bp_bresp", bus.bresp, 2'b00);
            check("bp_awready", bus.awready, 0);
            check("bp_wready", bus.wready, 0);
            check("bp_byte_offset", bus.byte_offset, 1);
            step();
        end
        bus.bready = 1'b1;
        check("bp_awready_at_b", bus.awready, 0);
        check("bp_wready_at_b", bus.wready, 0);
        step();
        bus.bready = 1'b0;
        check("bp_bvalid_done", bus.bvalid, 0);
        check("bp_awready_after", bus.awready, 1);
        check("bp_wready_after", bus.wready, 1);
        check("bp_one_w_req", wreq_cnt - c0, 1);

        // Highest legal register (no error), then first out-of-range index
        bus.awvalid = 1'b1; bus.awaddr = 8'h3C;
        bus.wvalid = 1'b1; bus.wdata = 32'h0000_00FF; bus.wstrb = 4'h1;
        step();
        idle_inputs();
        check("hi_w_req", bus.w_req, 1);
        check("hi_reg_idx", bus.reg_idx, 15);
        check("hi_w_error", bus.w_error, 0);
        step();
        check("hi_bresp", bus.bresp, 2'b00);
        bus.bready = 1'b1;
        step();
        bus.bready = 1'b0;

        bus.awvalid = 1'b1; bus.awaddr = 8'h40;
        bus.wvalid = 1'b1; bus.wdata = 32'h5555_AAAA; bus.wstrb = 4'hF;
        step();
        idle_inputs();
        check("oor_w_req", bus.w_req, 1);
        check("oor_reg_idx", bus.reg_idx, 16);
        check("oor_w_error", bus.w_error, 1);
        step();
        check("oor_bvalid", bus.bvalid, 1);
        check("oor_bresp", bus.bresp, 2'b10);
        bus.bready = 1'b1;
        step();
        bus.bready = 1'b0;
        check("oor_bvalid_done", bus.bvalid, 0);

        // Back-to-back: valids and bready held high, 8 writes
        idx = 0; nreq = 0; last_req = -1;
        bus.bready  = 1'b1;
        bus.awvalid = 1'b1; bus.awaddr = 8'(idx * 4);
        bus.wvalid  = 1'b1; bus.wdata = data_tbl[idx]; bus.wstrb = strb_tbl[idx];
        #1;
        hs_pending = bus.awready & bus.wready;
        for (int cyc = 0; cyc < 30; cyc++) begin
            step();
            if (hs_pending) begin
                exp_q.push_back({6'(idx), strb_tbl[idx], data_tbl[idx]});
                idx++;
                if (idx < 8) begin
                    bus.awaddr = 8'(idx * 4);
                    bus.wdata  = data_tbl[idx];
                    bus.wstrb  = strb_tbl[idx];
                end else begin
                    bus.awvalid = 1'b0;
                    bus.wvalid  = 1'b0;
                end
            end
            if (bus.w_req === 1'b1) begin
                nreq++;
                if (exp_q.size() == 0) begin
                    check("b2b_unexpected_w_req", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    check("b2b_beat", {bus.reg_idx, bus.w_strb, bus.w_data}, e);
                end
                if (last_req >= 0) check("b2b_gap", cyc - last_req, 3);
                last_req = cyc;
            end
            hs_pending = bus.awvalid & bus.awready & bus.wvalid & bus.wready;
        end
        idle_inputs();
        check("b2b_count", nreq, 8);
        check("b2b_queue_empty", exp_q.size(), 0);

        // Reset asserted while in RESP
        bus.awvalid = 1'b1; bus.awaddr = 8'h04;
        bus.wvalid = 1'b1; bus.wdata = 32'h0BAD_F00D; bus.wstrb = 4'hF;
        step();
        idle_inputs();
        step();
        check("mr_bvalid_pre", bus.bvalid, 1);
        #2 rst = 1'b1;
        #1;
        check("mr_bvalid_async", bus.bvalid, 0);
        check("mr_awready_async", bus.awready, 1);
        check("mr_wready_async", bus.wready, 1);
        check("mr_state_async", bus.dbg_state, 0);
        repeat (3) @(posedge clk);
        step();
        rst = 1'b0;
        c0 = wreq_cnt;
        for (int i = 0; i < 5; i++) begin
            step();
            check("mr_no_bvalid", bus.bvalid, 0);
        end
        check("mr_no_w_req", wreq_cnt - c0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
